// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the MIPS execute stage.
// The master is the pipeline side; the slave is ex_stage itself.
interface ex_stage_if;
    logic [1:0]  ALUOp;
    logic [5:0]  funct;
    logic        ALUSrc;
    logic        RegDst;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic [31:0] rfile_rd1;
    logic [31:0] rfile_rd2;
    logic [31:0] extend_immed;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        exmem_regwrite;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_regwrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;

    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  wr_reg;
    logic        zero;
    logic        RegWrite_ex;
    logic        MemRead_ex;
    logic        MemWrite_ex;
    logic        MemtoReg_ex;
    logic        stall;

    modport master (
        output ALUOp, funct, ALUSrc, RegDst, RegWrite, MemRead, MemWrite, MemtoReg,
        output rfile_rd1, rfile_rd2, extend_immed, rs, rt, rd,
        output exmem_regwrite, exmem_rd, exmem_result,
        output memwb_regwrite, memwb_rd, memwb_result,
        input  alu_result, store_data, wr_reg, zero,
        input  RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, stall
    );

    modport slave (
        input  ALUOp, funct, ALUSrc, RegDst, RegWrite, MemRead, MemWrite, MemtoReg,
        input  rfile_rd1, rfile_rd2, extend_immed, rs, rt, rd,
        input  exmem_regwrite, exmem_rd, exmem_result,
        input  memwb_regwrite, memwb_rd, memwb_result,
        output alu_result, store_data, wr_reg, zero,
        output RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, stall
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, ALU, destination select and control gating.
// `define EX_MULDIV_EN adds the iterative multu/divu unit with HI/LO and front-end stall.
module ex_stage (
    input logic       clk,
    input logic       rst,
    ex_stage_if.slave bus
);
    localparam logic [5:0] FnAdd   = 6'h20;
    localparam logic [5:0] FnSub   = 6'h22;
    localparam logic [5:0] FnAnd   = 6'h24;
    localparam logic [5:0] FnOr    = 6'h25;
    localparam logic [5:0] FnSlt   = 6'h2A;
`ifdef EX_MULDIV_EN
    localparam logic [5:0] FnMultu = 6'h19;
    localparam logic [5:0] FnDivu  = 6'h1B;
    localparam logic [5:0] FnMfhi  = 6'h10;
    localparam logic [5:0] FnMflo  = 6'h12;
`endif

    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic        stall;

    // EX/MEM wins over MEM/WB; register 0 is never forwarded.
    always_comb begin
        fwd_a = bus.rfile_rd1;
        if (bus.exmem_regwrite && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == bus.rs)) begin
            fwd_a = bus.exmem_result;
        end else if (bus.memwb_regwrite && (bus.memwb_rd != 5'd0) &&
                     (bus.memwb_rd == bus.rs)) begin
            fwd_a = bus.memwb_result;
        end
    end

    always_comb begin
        fwd_b = bus.rfile_rd2;
        if (bus.exmem_regwrite && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == bus.rt)) begin
            fwd_b = bus.exmem_result;
        end else if (bus.memwb_regwrite && (bus.memwb_rd != 5'd0) &&
                     (bus.memwb_rd == bus.rt)) begin
            fwd_b = bus.memwb_result;
        end
    end

    assign op_b = bus.ALUSrc ? bus.extend_immed : fwd_b;

`ifdef EX_MULDIV_EN
    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} md_state_e;

    md_state_e   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        is_multu;
    logic        is_divu;
    logic [32:0] mul_sum;
    logic [32:0] div_top;
    logic [32:0] div_diff;

    assign is_multu = (bus.ALUOp == 2'b10) && (bus.funct == FnMultu);
    assign is_divu  = (bus.ALUOp == 2'b10) && (bus.funct == FnDivu);

    // acc holds {upper, lower}: product accumulator for multu, {remainder, quotient} for divu.
    assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    assign div_top  = acc_q[63:31];
    assign div_diff = div_top - {1'b0, opnd_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle: begin
                if (is_multu) begin
                    state_d = StMul;
                    cnt_d   = 5'd31;
                    opnd_d  = fwd_a;
                    acc_d   = {32'd0, fwd_b};
                end else if (is_divu) begin
                    state_d = StDiv;
                    cnt_d   = 5'd31;
                    opnd_d  = fwd_b;
                    acc_d   = {32'd0, fwd_a};
                end
            end
            StMul, StDiv: begin
                if (state_q == StMul) begin
                    acc_d = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
                end else if (div_top >= {1'b0, opnd_q}) begin
                    acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
                end else begin
                    acc_d = {div_top[31:0], acc_q[30:0], 1'b0};
                end
                if (cnt_q == 5'd0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StDone: begin
                hi_d    = acc_q[63:32];
                lo_d    = acc_q[31:0];
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            opnd_q  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign stall = rst & (((state_q == StIdle) & (is_multu | is_divu)) |
                          (state_q == StMul) | (state_q == StDiv));
`else
    logic unused_clk;
    assign unused_clk = clk;
    assign stall      = 1'b0;
`endif

    always_comb begin
        alu_res = 32'd0;
        unique case (bus.ALUOp)
            2'b01: alu_res = fwd_a - op_b;
            2'b10: begin
                case (bus.funct)
                    FnAdd:   alu_res = fwd_a + op_b;
                    FnSub:   alu_res = fwd_a - op_b;
                    FnAnd:   alu_res = fwd_a & op_b;
                    FnOr:    alu_res = fwd_a | op_b;
                    FnSlt:   alu_res = {31'd0, $signed(fwd_a) < $signed(op_b)};
`ifdef EX_MULDIV_EN
                    FnMfhi:  alu_res = hi_q;
                    FnMflo:  alu_res = lo_q;
`endif
                    default: alu_res = 32'd0;
                endcase
            end
            default: alu_res = fwd_a + op_b;
        endcase
    end

    assign bus.alu_result = alu_res;
    assign bus.zero       = (alu_res == 32'd0);
    assign bus.store_data = fwd_b;
    assign bus.wr_reg     = bus.RegDst ? bus.rd : bus.rt;
    assign bus.stall      = stall;

    // Controls are killed while in reset or while the front end is held.
`ifdef EX_MULDIV_EN
    assign bus.RegWrite_ex = rst & ~stall & bus.RegWrite & ~(is_multu | is_divu);
`else
    assign bus.RegWrite_ex = rst & ~stall & bus.RegWrite;
`endif
    assign bus.MemRead_ex  = rst & ~stall & bus.MemRead;
    assign bus.MemWrite_ex = rst & ~stall & bus.MemWrite;
    assign bus.MemtoReg_ex = rst & ~stall & bus.MemtoReg;
endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage; multu/divu vectors apply when EX_MULDIV_EN is defined.
module tb_ex_stage;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    ex_stage_if bus ();

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Plain R/I operation with no forwarding hits.
    task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        bus.ALUOp          = op;
        bus.funct          = fn;
        bus.rfile_rd1      = a;
        bus.rfile_rd2      = b;
        bus.ALUSrc         = 1'b0;
        bus.RegDst         = 1'b1;
        bus.rs             = 5'd1;
        bus.rt             = 5'd2;
        bus.rd             = 5'd3;
        bus.exmem_regwrite = 1'b0;
        bus.memwb_regwrite = 1'b0;
    endtask

`ifdef EX_MULDIV_EN
    // Issue multu/divu, count stall cycles, scribble on inputs after issue, end after DONE edge.
    task automatic run_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          output int n_stall, output logic rw_seen);
        n_stall = 0;
        rw_seen = 1'b0;
        @(negedge clk);
        drive(2'b10, fn, a, b);
        bus.RegWrite = 1'b1;
        #1;
        for (int i = 0; i < 100; i++) begin
            if (!bus.stall) break;
            n_stall++;
            if (bus.RegWrite_ex) rw_seen = 1'b1;
            @(negedge clk);
            bus.rfile_rd1      = 32'hDEAD_BEEF;
            bus.rfile_rd2      = 32'h0BAD_F00D;
            bus.exmem_regwrite = 1'b1;
            bus.exmem_rd       = 5'd1;
            bus.exmem_result   = 32'h1234_5678;
            #1;
        end
        if (bus.RegWrite_ex) rw_seen = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        drive(2'b10, 6'h10, 32'd0, 32'd0);
        #1;
        check({tag, " mfhi"}, bus.alu_result, hi);
        bus.funct = 6'h12;
        #1;
        check({tag, " mflo"}, bus.alu_result, lo);
    endtask
`endif

    initial begin
        int   n_stall;
        logic rw_seen;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        drive(2'b00, 6'h00, 32'd0, 32'd0);
        bus.extend_immed = 32'd0;
        bus.RegWrite     = 1'b1;
        bus.MemRead      = 1'b1;
        bus.MemWrite     = 1'b1;
        bus.MemtoReg     = 1'b1;
        bus.exmem_rd     = 5'd0;
        bus.exmem_result = 32'd0;
        bus.memwb_rd     = 5'd0;
        bus.memwb_result = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("reset stall", {31'd0, bus.stall}, 32'd0);
        check("reset gated ctl", {28'd0, bus.RegWrite_ex, bus.MemRead_ex, bus.MemWrite_ex,
                                  bus.MemtoReg_ex}, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        // Forwarding priority: EX/MEM over MEM/WB.
        drive(2'b00, 6'h00, 32'h0000_0040, 32'h0000_0050);
        bus.rs = 5'd5; bus.rt = 5'd5; bus.ALUSrc = 1'b1; bus.extend_immed = 32'd1;
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd5; bus.exmem_result = 32'h11;
        bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd5; bus.memwb_result = 32'h22;
        #1;
        check("fwd exmem prio", bus.alu_result, 32'h12);
        check("fwd store_data", bus.store_data, 32'h11);
        check("gated ctl pass", {28'd0, bus.RegWrite_ex, bus.MemRead_ex, bus.MemWrite_ex,
                                 bus.MemtoReg_ex}, 32'hF);
        bus.exmem_regwrite = 1'b0;
        #1;
        check("fwd memwb", bus.alu_result, 32'h23);
        bus.memwb_regwrite = 1'b0;
        #1;
        check("fwd none", bus.alu_result, 32'h41);

        // Register 0 is never forwarded.
        drive(2'b00, 6'h00, 32'd0, 32'd3);
        bus.rs = 5'd0; bus.rt = 5'd3;
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'hFF;
        #1;
        check("r0 guard", bus.alu_result, 32'd3);

        drive(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1);
        #1;
        check("slt signed", bus.alu_result, 32'd1);
        check("slt zero", {31'd0, bus.zero}, 32'd0);
        drive(2'b10, 6'h2A, 32'd1, 32'hFFFF_FFFF);
        #1;
        check("slt false", bus.alu_result, 32'd0);
        drive(2'b01, 6'h00, 32'd7, 32'd7);
        #1;
        check("sub zero", {31'd0, bus.zero}, 32'd1);
        drive(2'b10, 6'h22, 32'd5, 32'd7);
        #1;
        check("sub wrap", bus.alu_result, 32'hFFFF_FFFE);
        drive(2'b10, 6'h24, 32'h0000_F0F0, 32'h0000_FF00);
        #1;
        check("and", bus.alu_result, 32'h0000_F000);
        bus.funct = 6'h25;
        #1;
        check("or", bus.alu_result, 32'h0000_FFF0);
        bus.funct = 6'h20;
        bus.rfile_rd1 = 32'hFFFF_FFFF;
        #1;
        check("add wrap", bus.alu_result, 32'h0000_FEFF);
        bus.funct = 6'h3F;
        #1;
        check("unknown funct", bus.alu_result, 32'd0);
        check("wr_reg rd", {27'd0, bus.wr_reg}, 32'd3);
        bus.RegDst = 1'b0;
        #1;
        check("wr_reg rt", {27'd0, bus.wr_reg}, 32'd2);
        drive(2'b11, 6'h00, 32'd10, 32'd0);
        bus.ALUSrc = 1'b1; bus.extend_immed = 32'hFFFF_FFFC;
        #1;
        check("aluop11 add imm", bus.alu_result, 32'd6);

`ifdef EX_MULDIV_EN
        run_md(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n_stall, rw_seen);
        check("multu stall cycles", n_stall, 33);
        check("multu regwrite", {31'd0, rw_seen}, 32'd0);
        check_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);
        check("mfhi no stall", {31'd0, bus.stall}, 32'd0);

        run_md(6'h1B, 32'd100, 32'd7, n_stall, rw_seen);
        check("divu stall cycles", n_stall, 33);
        check_hilo("divu 100/7", 32'd2, 32'd14);
        run_md(6'h1B, 32'd9, 32'd0, n_stall, rw_seen);
        check_hilo("divu 9/0", 32'd9, 32'hFFFF_FFFF);

        // Reset in the middle of a multu.
        @(negedge clk);
        drive(2'b10, 6'h19, 32'd3, 32'd5);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst mid stall", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        check_hilo("after reset", 32'd0, 32'd0);
        drive(2'b10, 6'h20, 32'd2, 32'd3);
        bus.RegWrite = 1'b1;
        #1;
        check("post reset add", bus.alu_result, 32'd5);
        check("post reset stall", {31'd0, bus.stall}, 32'd0);
        check("post reset regwr", {31'd0, bus.RegWrite_ex}, 32'd1);
        @(negedge clk);
        #1;
        check("post reset stall2", {31'd0, bus.stall}, 32'd0);
`else
        drive(2'b10, 6'h19, 32'd3, 32'd5);
        #1;
        check("multu disabled", bus.alu_result, 32'd0);
        check("no stall", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        #1;
        check("no stall later", {31'd0, bus.stall}, 32'd0);
        bus.funct = 6'h10;
        #1;
        check("mfhi disabled", bus.alu_result, 32'd0);
        bus.funct = 6'h1B;
        #1;
        check("divu regwr", {31'd0, bus.RegWrite_ex}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
